svf_voice_scheduler: RTL and testbench

- Time-multiplexes one state_variable_filter_iir instance across VOICES oscillator voices.
- On each sample tick it walks the active voices in order. For each active voice it presents that voice's midi and sample to the filter, waits out the filter latency and captures the result.
- Filtered results are summed into one saturated 16-bit mix sample.
- Sits between phase_bank/quarter_sine (per-voice samples) and the output DAC path.

---
 rtl/svf_pkg.sv | 20 ++
 rtl/sat_accumulator.sv | 54 +++++
 rtl/svf_voice_scheduler.sv | 173 +++++++++++++++++
 tb/tb_svf_voice_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/svf_pkg.sv
// Shared definitions for the state-variable-filter voice scheduler and related mixers.
// Contents: sample/midi widths, scheduler FSM encoding, 16-bit saturation limits.
package svf_pkg;

  localparam int unsigned MIDI_W   = 7;
  localparam int unsigned SAMPLE_W = 16;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StIssue,
    StWait,
    StCapture,
    StDone
  } svf_state_e;

endpackage

// File: rtl/sat_accumulator.sv
// Wide signed accumulator with a saturated 16-bit view.
// Ports:
//   clk_i   clock (rising edge)
//   rst_i   asynchronous active-high reset, clears the accumulator
//   clr_i   synchronous clear (wins over add_i)
//   add_i   add sign-extended data_i into the accumulator
//   data_i  signed sample to add
//   sat_o   accumulator clamped to [SAT_MIN, SAT_MAX]
module sat_accumulator
  import svf_pkg::*;
#(
  parameter int unsigned AW = SAMPLE_W + 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       add_i,
  input  logic signed [SAMPLE_W-1:0] data_i,
  output logic signed [SAMPLE_W-1:0] sat_o
);

  localparam logic signed [AW-1:0] AccMax = {{(AW - SAMPLE_W){1'b0}}, SAT_MAX};
  localparam logic signed [AW-1:0] AccMin = {{(AW - SAMPLE_W){1'b1}}, SAT_MIN};

  logic signed [AW-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = acc_q + {{(AW - SAMPLE_W){data_i[SAMPLE_W-1]}}, data_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  always_comb begin
    if (acc_q > AccMax) begin
      sat_o = SAT_MAX;
    end else if (acc_q < AccMin) begin
      sat_o = SAT_MIN;
    end else begin
      sat_o = acc_q[SAMPLE_W-1:0];
    end
  end

endmodule

// File: rtl/svf_voice_scheduler.sv
// Time-multiplexes one state-variable filter across VOICES voices per sample frame and
// sums the filtered active voices into a saturated 16-bit mix.
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   i_sample_tick            frame start pulse
//   i_active/i_voice_midi/i_voice_data  per-voice mask, midi note, signed sample
//   o_flt_ena/voice/midi/data  issue strobe and operands to the filter
//   i_flt_data               filter result, valid FLT_LAT cycles after o_flt_ena
//   o_mix, o_mix_valid       saturated mix and its one-cycle update pulse
//   o_busy                   frame in progress
//   o_overrun                sticky: tick arrived while busy
module svf_voice_scheduler
  import svf_pkg::*;
#(
  parameter int unsigned VOICES  = 8,
  parameter int unsigned FLT_LAT = 3,
  parameter int unsigned VW      = $clog2(VOICES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_sample_tick,
  input  logic [VOICES-1:0]            i_active,
  input  logic [MIDI_W*VOICES-1:0]     i_voice_midi,
  input  logic [SAMPLE_W*VOICES-1:0]   i_voice_data,
  output logic                         o_flt_ena,
  output logic [VW-1:0]                o_flt_voice,
  output logic [MIDI_W-1:0]            o_flt_midi,
  output logic signed [SAMPLE_W-1:0]   o_flt_data,
  input  logic signed [SAMPLE_W-1:0]   i_flt_data,
  output logic signed [SAMPLE_W-1:0]   o_mix,
  output logic                         o_mix_valid,
  output logic                         o_busy,
  output logic                         o_overrun
);

  localparam logic [VW-1:0] LastIdx = VW'(VOICES - 1);
  localparam logic [7:0]    WaitEnd = 8'(FLT_LAT - 2);

  svf_state_e state_q, state_d;
  logic [VW-1:0] idx_q, idx_d;
  logic [7:0]    wait_q, wait_d;

  logic [VOICES-1:0]          snap_active_q;
  logic [MIDI_W*VOICES-1:0]   snap_midi_q;
  logic [SAMPLE_W*VOICES-1:0] snap_data_q;

  logic [VW-1:0]               flt_voice_q;
  logic [MIDI_W-1:0]           flt_midi_q;
  logic signed [SAMPLE_W-1:0]  flt_data_q;
  logic signed [SAMPLE_W-1:0]  mix_q;
  logic                        mix_valid_q;
  logic                        overrun_q;

  logic                        cur_active;
  logic [MIDI_W-1:0]           cur_midi;
  logic signed [SAMPLE_W-1:0]  cur_data;
  logic                        issue;
  logic                        start;
  logic                        acc_clr, acc_add;
  logic signed [SAMPLE_W-1:0]  sat_mix;

  assign cur_active = snap_active_q[idx_q];
  assign cur_midi   = snap_midi_q[int'(idx_q)*MIDI_W +: MIDI_W];
  assign cur_data   = snap_data_q[int'(idx_q)*SAMPLE_W +: SAMPLE_W];
  assign issue      = (state_q == StIssue) && cur_active;
  // Snapshot is taken on the tick edge so changes during LATCH cannot leak in.
  assign start      = (state_q == StIdle) && i_sample_tick;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    acc_clr = 1'b0;
    acc_add = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_sample_tick) state_d = StLatch;
      end
      StLatch: begin
        acc_clr = 1'b1;
        idx_d   = '0;
        state_d = (snap_active_q == '0) ? StDone : StIssue;
      end
      StIssue: begin
        if (cur_active) begin
          wait_d  = '0;
          state_d = (FLT_LAT > 1) ? StWait : StCapture;
        end else begin
          idx_d = idx_q + VW'(1);
          if (idx_q == LastIdx) state_d = StDone;
        end
      end
      StWait: begin
        if (wait_q == WaitEnd) begin
          state_d = StCapture;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StCapture: begin
        acc_add = 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + VW'(1);
          state_d = StIssue;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      wait_q        <= '0;
      snap_active_q <= '0;
      snap_midi_q   <= '0;
      snap_data_q   <= '0;
      flt_voice_q   <= '0;
      flt_midi_q    <= '0;
      flt_data_q    <= '0;
      mix_q         <= '0;
      mix_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      mix_valid_q <= (state_q == StDone);
      overrun_q   <= overrun_q | (i_sample_tick && (state_q != StIdle));
      if (start) begin
        snap_active_q <= i_active;
        snap_midi_q   <= i_voice_midi;
        snap_data_q   <= i_voice_data;
      end
      if (issue) begin
        flt_voice_q <= idx_q;
        flt_midi_q  <= cur_midi;
        flt_data_q  <= cur_data;
      end
      if (state_q == StDone) mix_q <= sat_mix;
    end
  end

  sat_accumulator #(
    .AW (SAMPLE_W + VW)
  ) u_acc (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (acc_clr),
    .add_i  (acc_add),
    .data_i (i_flt_data),
    .sat_o  (sat_mix)
  );

  // Operands are live during the issue cycle and hold their last issued values after.
  assign o_flt_ena   = issue;
  assign o_flt_voice = issue ? idx_q    : flt_voice_q;
  assign o_flt_midi  = issue ? cur_midi : flt_midi_q;
  assign o_flt_data  = issue ? cur_data : flt_data_q;
  assign o_mix       = mix_q;
  assign o_mix_valid = mix_valid_q;
  assign o_busy      = (state_q != StIdle);
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_svf_voice_scheduler.sv
module tb_svf_voice_scheduler;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               i_sample_tick = 1'b0;
  logic [7:0]         i_active = '0;
  logic [55:0]        i_voice_midi = '0;
  logic [127:0]       i_voice_data = '0;
  logic               o_flt_ena;
  logic [2:0]         o_flt_voice;
  logic [6:0]         o_flt_midi;
  logic signed [15:0] o_flt_data;
  logic signed [15:0] i_flt_data;
  logic signed [15:0] o_mix;
  logic               o_mix_valid;
  logic               o_busy;
  logic               o_overrun;

  int vectors = 0;
  int miscompares = 0;

  int q_voice[$];
  int q_data[$];
  int q_midi[$];
  int valid_total = 0;

  logic signed [15:0] d1 = '0, d2 = '0, d3 = '0;

  always #5 clk = ~clk;

  svf_voice_scheduler #(
    .VOICES  (8),
    .FLT_LAT (3),
    .VW      (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_sample_tick (i_sample_tick),
    .i_active      (i_active),
    .i_voice_midi  (i_voice_midi),
    .i_voice_data  (i_voice_data),
    .o_flt_ena     (o_flt_ena),
    .o_flt_voice   (o_flt_voice),
    .o_flt_midi    (o_flt_midi),
    .o_flt_data    (o_flt_data),
    .i_flt_data    (i_flt_data),
    .o_mix         (o_mix),
    .o_mix_valid   (o_mix_valid),
    .o_busy        (o_busy),
    .o_overrun     (o_overrun)
  );

  // Unity-gain filter stub: returns the issued sample three cycles after the strobe.
  always @(posedge clk) begin
    d1 <= o_flt_data;
    d2 <= d1;
    d3 <= d2;
  end
  assign i_flt_data = d3;

  always @(negedge clk) begin
    if (o_flt_ena) begin
      q_voice.push_back(int'(o_flt_voice));
      q_data.push_back(int'(o_flt_data));
      q_midi.push_back(int'(o_flt_midi));
    end
    if (o_mix_valid) valid_total++;
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_voice(input int v, input int midi, input int data);
    i_voice_midi[7*v +: 7]   = 7'(midi);
    i_voice_data[16*v +: 16] = 16'(data);
  endtask

  // Runs one frame; lat = posedges from the tick edge (counted as 1) to o_mix_valid, or -1.
  task automatic run_frame(input bit scramble, input bit overtick, output int lat);
    int  n;
    bit  seen;
    @(negedge clk);
    i_sample_tick = 1'b1;
    @(posedge clk);
    #1;
    i_sample_tick = 1'b0;
    if (scramble) begin
      i_active = '0;
      for (int v = 0; v < 8; v++) set_voice(v, 1, 9999);
    end
    n = 1;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk);
      n++;
      #1;
      i_sample_tick = (overtick && n == 4);
      if (o_mix_valid) seen = 1'b1;
    end
    i_sample_tick = 1'b0;
    lat = seen ? n : -1;
    @(negedge clk);
    #1;
  endtask

  initial begin
    int lat, base, vbase;

    #1 rst = 1'b1;
    #1;
    check("reset_busy", o_busy, 0);
    check("reset_ena", o_flt_ena, 0);
    check("reset_mix", o_mix, 0);
    check("reset_valid", o_mix_valid, 0);
    check("reset_overrun", o_overrun, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single voice
    i_active = 8'b0000_0001;
    set_voice(0, 60, 1000);
    base = q_voice.size();
    vbase = valid_total;
    run_frame(1'b0, 1'b0, lat);
    check("single_latency", lat, 14);
    check("single_ena_count", q_voice.size() - base, 1);
    check("single_voice", q_voice[base], 0);
    check("single_midi", q_midi[base], 60);
    check("single_data", q_data[base], 1000);
    check("single_mix", o_mix, 1000);
    check("single_valid_count", valid_total - vbase, 1);
    check("single_busy_after", o_busy, 0);

    // All voices, positive saturation
    i_active = 8'hFF;
    for (int v = 0; v < 8; v++) set_voice(v, 40 + v, 5000);
    base = q_voice.size();
    run_frame(1'b0, 1'b0, lat);
    check("all_latency", lat, 35);
    check("all_ena_count", q_voice.size() - base, 8);
    for (int i = 0; i < 8; i++) check($sformatf("all_voice%0d", i), q_voice[base + i], i);
    check("all_midi7", q_midi[base + 7], 47);
    check("all_mix_pos_sat", o_mix, 32767);

    // All voices, negative saturation
    for (int v = 0; v < 8; v++) set_voice(v, 40 + v, -5000);
    run_frame(1'b0, 1'b0, lat);
    check("all_mix_neg_sat", o_mix, -32768);

    // Empty mask
    i_active = '0;
    base = q_voice.size();
    run_frame(1'b0, 1'b0, lat);
    check("empty_latency", lat, 3);
    check("empty_ena_count", q_voice.size() - base, 0);
    check("empty_mix", o_mix, 0);

    // Snapshot: inputs scrambled right after the tick
    i_active = 8'b1010_0000;
    set_voice(5, 21, 100);
    set_voice(7, 22, 200);
    base = q_voice.size();
    run_frame(1'b1, 1'b0, lat);
    check("snap_latency", lat, 17);
    check("snap_ena_count", q_voice.size() - base, 2);
    check("snap_voice_a", q_voice[base], 5);
    check("snap_data_a", q_data[base], 100);
    check("snap_voice_b", q_voice[base + 1], 7);
    check("snap_data_b", q_data[base + 1], 200);
    check("snap_mix", o_mix, 300);

    // Overrun: second tick mid-frame
    i_active = 8'b0000_0001;
    set_voice(0, 10, 7);
    base = q_voice.size();
    vbase = valid_total;
    check("pre_overrun", o_overrun, 0);
    run_frame(1'b0, 1'b1, lat);
    check("ovr_latency", lat, 14);
    check("ovr_flag", o_overrun, 1);
    check("ovr_mix", o_mix, 7);
    repeat (20) @(negedge clk);
    check("ovr_no_restart_busy", o_busy, 0);
    check("ovr_valid_count", valid_total - vbase, 1);
    check("ovr_ena_count", q_voice.size() - base, 1);
    check("ovr_sticky", o_overrun, 1);

    // Reset while waiting on the filter
    i_active = 8'b0000_0010;
    set_voice(1, 33, 1234);
    vbase = valid_total;
    @(negedge clk);
    i_sample_tick = 1'b1;
    @(posedge clk);
    #1 i_sample_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("wait_busy", o_busy, 1);
    check("wait_held_data", o_flt_data, 1234);
    check("wait_held_voice", o_flt_voice, 1);
    rst = 1'b1;
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_ena", o_flt_ena, 0);
    check("rst_voice", o_flt_voice, 0);
    check("rst_midi", o_flt_midi, 0);
    check("rst_data", o_flt_data, 0);
    check("rst_mix", o_mix, 0);
    check("rst_valid", o_mix_valid, 0);
    check("rst_overrun", o_overrun, 0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_no_valid", valid_total - vbase, 0);

    // Clean frame after reset
    i_active = 8'b0000_0011;
    set_voice(0, 1, 11);
    set_voice(1, 2, 22);
    base = q_voice.size();
    run_frame(1'b0, 1'b0, lat);
    check("post_latency", lat, 3 + 6 + 8);
    check("post_ena_count", q_voice.size() - base, 2);
    check("post_mix", o_mix, 33);
    check("post_overrun", o_overrun, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
